uart_rx_axis: RTL

UART receiver: the receive-side counterpart of the team's AXI-Stream UART transmitter. Oversamples the serial `rxd` line with the same `prescale` convention (one bit = prescale×8 clocks), recovers 8N1 frames LSB-first, and presents each byte on an AXI-Stream master port. It flags framing errors and overrun errors as single-cycle pulses.

---
 rtl/uart_rx_axis.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_axis.sv
// -----------------------------------------------------------------------------
// uart_rx_axis
//
// Oversampling 8N1 UART receiver with an AXI-Stream master output. One bit
// period is prescale*8 clocks; the start bit is checked half a bit period
// after the falling edge, then every data bit and the stop bit are sampled
// one full bit period apart. Received bytes are held in an output register
// until the consumer takes them.
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   : each sample point uses a 2-of-3 majority of the synchronized
//               line at sample-1, sample and sample+1; decisions (and all
//               output timing) land one cycle later than the single-sample
//               build, and single-cycle glitches at a sample point are ignored.
//   undefined : single sample at the sample point.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   m_axis_tdata   out  received byte, stable while m_axis_tvalid is high
//   m_axis_tvalid  out  byte available
//   m_axis_tready  in   consumer accepts the byte
//   rxd            in   asynchronous serial input, idle high
//   busy           out  frame reception in progress
//   overrun_error  out  one-cycle pulse: unconsumed byte was overwritten
//   frame_error    out  one-cycle pulse: stop bit sampled low
//   prescale       in   bit period in units of 8 clocks (0 behaves as 1)
// -----------------------------------------------------------------------------
module uart_rx_axis #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);

    localparam int SYNC_STAGES = 2;
    localparam int IDX_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchronizer. Resets to 1 so the line looks idle out of reset.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_sync[gi] <= 1'b1;
                    end else begin
                        r_sync[gi] <= rxd;
                    end
                end
            end else begin : g_chain
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_sync[gi] <= 1'b1;
                    end else begin
                        r_sync[gi] <= r_sync[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign w_rxs = r_sync[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Sample value used at every decision point.
    // -------------------------------------------------------------------------
    logic w_sample;

`ifdef UART_RX_MAJORITY_EN
    // History of the synchronized line: at a decision cycle (sample+1),
    // r_rxs_d1 holds the value at the nominal sample point and r_rxs_d2 the
    // value one cycle before it.
    logic r_rxs_d1;
    logic r_rxs_d2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxs_d1 <= 1'b1;
            r_rxs_d2 <= 1'b1;
        end else begin
            r_rxs_d1 <= w_rxs;
            r_rxs_d2 <= r_rxs_d1;
        end
    end

    assign w_sample = (r_rxs_d2 & r_rxs_d1) | (r_rxs_d2 & w_rxs) | (r_rxs_d1 & w_rxs);
`else
    assign w_sample = w_rxs;
`endif

    // -------------------------------------------------------------------------
    // Bit timing. prescale of 0 is promoted to 1; periods are 19 bits wide so
    // prescale*8 never overflows.
    // -------------------------------------------------------------------------
    logic [15:0] w_pre_eff;
    logic [18:0] w_full_per;
    logic [18:0] w_half_per;
    logic [18:0] w_start_load;

    assign w_pre_eff  = (prescale == 16'd0) ? 16'd1 : prescale;
    assign w_full_per = {w_pre_eff, 3'b000};
    assign w_half_per = {1'b0, w_pre_eff, 2'b00};

    // The counter is loaded at the detection cycle t0 and the decision is taken
    // when it reaches zero. Loading H-1 puts the decision at t0+H; the majority
    // build needs one extra cycle to see sample+1, so it loads H.
`ifdef UART_RX_MAJORITY_EN
    assign w_start_load = w_half_per;
`else
    assign w_start_load = w_half_per - 19'd1;
`endif

    // -------------------------------------------------------------------------
    // Receive FSM state and datapath registers
    // -------------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_next;
    logic [18:0]           r_cnt;
    logic [18:0]           w_cnt_next;
    logic [18:0]           r_bit_per;       // bit period latched at start detection
    logic [18:0]           w_bit_per_next;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [IDX_W-1:0]      w_bit_idx_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  r_armed;
    logic                  w_tick;
    logic                  w_stop_ok;
    logic                  w_stop_bad;

    assign w_tick = (r_cnt == 19'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 19'd0;
            r_bit_per <= 19'd8;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_per <= w_bit_per_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_per_next = r_bit_per;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_stop_ok      = 1'b0;
        w_stop_bad     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_armed && !w_rxs) begin
                    w_state_next   = ST_START;
                    w_cnt_next     = w_start_load;
                    w_bit_per_next = w_full_per;
                    w_bit_idx_next = '0;
                end
            end

            ST_START: begin
                if (w_tick) begin
                    if (w_sample) begin
                        // Line went back high: glitch, not a start bit.
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_DATA;
                        w_cnt_next   = r_bit_per - 19'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt - 19'd1;
                end
            end

            ST_DATA: begin
                if (w_tick) begin
                    // LSB first: each new bit enters at the top and moves down.
                    w_shift_next = (r_shift >> 1) |
                                   (DATA_WIDTH'(w_sample) << (DATA_WIDTH - 1));
                    w_cnt_next   = r_bit_per - 19'd1;
                    if (r_bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt - 19'd1;
                end
            end

            ST_STOP: begin
                if (w_tick) begin
                    w_state_next = ST_IDLE;
                    if (w_sample) begin
                        w_stop_ok = 1'b1;
                    end else begin
                        w_stop_bad = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt - 19'd1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Arming: a start edge is only accepted after the line has been seen high.
    // A framing error disarms, so a held-low break reports a single error and
    // nothing else until the line returns to idle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else if (w_stop_bad) begin
            r_armed <= 1'b0;
        end else if (w_rxs) begin
            r_armed <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output register, handshake and error pulses
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
            if (w_stop_ok) begin
                // A new byte always wins. It is only an overrun if the old
                // byte is not being taken in this very cycle.
                m_axis_tdata  <= r_shift;
                m_axis_tvalid <= 1'b1;
                overrun_error <= m_axis_tvalid && !m_axis_tready;
            end else begin
                if (m_axis_tvalid && m_axis_tready) begin
                    m_axis_tvalid <= 1'b0;
                end
                if (w_stop_bad) begin
                    frame_error <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule
